// File: rtl/axil2sreg_bridge_pkg.sv
// Shared definitions for the AXI4-Lite to simple register bus bridge:
// FSM state encodings, AXI response codes and the write-response helper.
package axil2sreg_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ISSUE = 3'd1,
        ST_WR_RESP  = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_RD_RESP  = 3'd5
    } state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [3:0] WSTRB_FULL      = 4'hF;

    // Only a full-word write reaches the register bus; anything else is refused.
    function automatic logic [1:0] wr_resp(input logic [3:0] strb);
        return (strb == WSTRB_FULL) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    endfunction

endpackage

// File: rtl/axil2sreg_bridge_if.sv
// AXI4-Lite channel bundle between the PS GP master and the register-bus bridge.
interface axil2sreg_bridge_if;

    logic [31:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

endinterface

// File: rtl/axil2sreg_bridge.sv
// AXI4-Lite slave that issues one-cycle en/wen strobes on the simple register bus,
// one transaction at a time, and returns registered slave read data after RD_LAT cycles.
module axil2sreg_bridge
    import axil2sreg_bridge_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int AW     = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    axil2sreg_bridge_if.slave    axil,
    output logic                 sreg_en_o,
    output logic                 sreg_wen_o,
    output logic [AW-1:0]        sreg_addr_o,
    output logic [31:0]          sreg_din_o,
    input  logic [31:0]          sreg_dout_i
);

    localparam int            CW       = $clog2(RD_LAT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(RD_LAT - 1);

    state_e          state_q, state_d;
    logic            aw_held_q, aw_held_d;
    logic            w_held_q, w_held_d;
    logic            ar_held_q, ar_held_d;
    logic            last_wr_q, last_wr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   awaddr_q, awaddr_d;
    logic [AW-1:0]   araddr_q, araddr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;

    logic            awready_q, awready_d;
    logic            wready_q, wready_d;
    logic            arready_q, arready_d;
    logic            bvalid_q, bvalid_d;
    logic [1:0]      bresp_q, bresp_d;
    logic            rvalid_q, rvalid_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            sreg_en_q, sreg_en_d;
    logic            sreg_wen_q, sreg_wen_d;
    logic [AW-1:0]   sreg_addr_q, sreg_addr_d;
    logic [31:0]     sreg_din_q, sreg_din_d;

    logic            aw_hs_s, w_hs_s, ar_hs_s;
    logic            wr_pend_s, rd_pend_s;
    logic            wr_done_s, rd_done_s;
    logic            unused_addr_hi_s;

    assign unused_addr_hi_s = ^{axil.s_axi_awaddr[31:AW], axil.s_axi_araddr[31:AW]};

    assign aw_hs_s   = axil.s_axi_awvalid && awready_q;
    assign w_hs_s    = axil.s_axi_wvalid  && wready_q;
    assign ar_hs_s   = axil.s_axi_arvalid && arready_q;
    assign wr_pend_s = aw_held_q && w_held_q;
    assign rd_pend_s = ar_held_q;
    assign wr_done_s = (state_q == ST_WR_RESP) && axil.s_axi_bready;
    assign rd_done_s = (state_q == ST_RD_RESP) && axil.s_axi_rready;

    // State, capture and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            ar_held_q   <= 1'b0;
            last_wr_q   <= 1'b0;
            cnt_q       <= {CW{1'b0}};
            awaddr_q    <= {AW{1'b0}};
            araddr_q    <= {AW{1'b0}};
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            arready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= AXI_RESP_OKAY;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'd0;
            sreg_en_q   <= 1'b0;
            sreg_wen_q  <= 1'b0;
            sreg_addr_q <= {AW{1'b0}};
            sreg_din_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            aw_held_q   <= aw_held_d;
            w_held_q    <= w_held_d;
            ar_held_q   <= ar_held_d;
            last_wr_q   <= last_wr_d;
            cnt_q       <= cnt_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            arready_q   <= arready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            sreg_en_q   <= sreg_en_d;
            sreg_wen_q  <= sreg_wen_d;
            sreg_addr_q <= sreg_addr_d;
            sreg_din_q  <= sreg_din_d;
        end
    end

    // Next-state: arbitration favours whichever access type was not served last.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_pend_s && (!rd_pend_s || !last_wr_q)) begin
                    state_d = ST_WR_ISSUE;
                end else if (rd_pend_s) begin
                    state_d = ST_RD_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_ISSUE: state_d = ST_WR_RESP;
            ST_WR_RESP: begin
                if (axil.s_axi_bready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_RD_ISSUE: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RD_RESP;
                end else begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_RESP: begin
                if (axil.s_axi_rready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RD_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Channel capture, held flags, arbitration history and read-latency counter.
    always_comb begin
        aw_held_d = wr_done_s ? 1'b0 : (aw_held_q || aw_hs_s);
        w_held_d  = wr_done_s ? 1'b0 : (w_held_q  || w_hs_s);
        ar_held_d = rd_done_s ? 1'b0 : (ar_held_q || ar_hs_s);
        awaddr_d  = aw_hs_s ? axil.s_axi_awaddr[AW-1:0] : awaddr_q;
        araddr_d  = ar_hs_s ? axil.s_axi_araddr[AW-1:0] : araddr_q;
        wdata_d   = w_hs_s  ? axil.s_axi_wdata : wdata_q;
        wstrb_d   = w_hs_s  ? axil.s_axi_wstrb : wstrb_q;
        if (state_d == ST_WR_ISSUE) begin
            last_wr_d = 1'b1;
        end else if (state_d == ST_RD_ISSUE) begin
            last_wr_d = 1'b0;
        end else begin
            last_wr_d = last_wr_q;
        end
        if ((state_q == ST_RD_WAIT) && (state_d == ST_RD_WAIT)) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = {CW{1'b0}};
        end
    end

    // Output decode from the upcoming state so every output leaves a flop.
    always_comb begin
        awready_d   = (state_d == ST_IDLE) && !aw_held_d;
        wready_d    = (state_d == ST_IDLE) && !w_held_d;
        arready_d   = (state_d == ST_IDLE) && !ar_held_d;
        bvalid_d    = (state_d == ST_WR_RESP);
        rvalid_d    = (state_d == ST_RD_RESP);
        bresp_d     = bresp_q;
        sreg_en_d   = 1'b0;
        sreg_wen_d  = 1'b0;
        sreg_addr_d = sreg_addr_q;
        sreg_din_d  = sreg_din_q;
        if (state_d == ST_WR_ISSUE) begin
            bresp_d = wr_resp(wstrb_q);
            if (wstrb_q == WSTRB_FULL) begin
                sreg_en_d   = 1'b1;
                sreg_wen_d  = 1'b1;
                sreg_addr_d = awaddr_q;
                sreg_din_d  = wdata_q;
            end else begin
                sreg_en_d   = 1'b0;
            end
        end else if (state_d == ST_RD_ISSUE) begin
            sreg_en_d   = 1'b1;
            sreg_addr_d = araddr_q;
        end else begin
            sreg_en_d   = 1'b0;
        end
        if ((state_q == ST_RD_WAIT) && (state_d == ST_RD_RESP)) begin
            rdata_d = sreg_dout_i;
        end else begin
            rdata_d = rdata_q;
        end
    end

    assign axil.s_axi_awready = awready_q;
    assign axil.s_axi_wready  = wready_q;
    assign axil.s_axi_arready = arready_q;
    assign axil.s_axi_bvalid  = bvalid_q;
    assign axil.s_axi_bresp   = bresp_q;
    assign axil.s_axi_rvalid  = rvalid_q;
    assign axil.s_axi_rdata   = rdata_q;
    assign axil.s_axi_rresp   = AXI_RESP_OKAY;
    assign sreg_en_o          = sreg_en_q;
    assign sreg_wen_o         = sreg_wen_q;
    assign sreg_addr_o        = sreg_addr_q;
    assign sreg_din_o         = sreg_din_q;

endmodule
